// File: rtl/qnigma_tcp_rx_strm.sv
// TCP receive payload writer: in-order bytes go to the circular RX RAM,
// RCV.NXT advances on clean segment end, window tracks free RAM space.
module qnigma_tcp_rx_strm #(
   parameter int D = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic [31:0]  isn,
   input  logic         hdr_v,
   input  logic [31:0]  seg_seq,
   input  logic [15:0]  seg_len,
   input  logic [7:0]   dat,
   input  logic         dat_v,
   input  logic         dat_end,
   input  logic         dat_err,
   input  logic [31:0]  app_ptr,
   output logic [D-1:0] ram_a,
   output logic [7:0]   ram_d,
   output logic         ram_w,
   output logic [31:0]  rcv_nxt,
   output logic [15:0]  win,
   output logic         ack,
   output logic         ooo,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

   state_t      state, state_nx;
   logic [15:0] len;
   logic [15:0] cnt;
   logic [15:0] cnt_end;
   logic [D-1:0] ptr;
   logic [31:0] used;
   logic [31:0] free;
   logic [15:0] win_nx;
   logic        take;
   logic        commit;
   logic        dup;

   assign used    = rcv_nxt - app_ptr;
   assign free    = (32'd1 << D) - used;
   assign win_nx  = (free > 32'h0000_FFFF) ? 16'hFFFF : free[15:0];
   assign take    = (state == STREAM) && dat_v && (cnt < len);
   assign cnt_end = take ? cnt + 16'd1 : cnt;
   assign commit  = (state == STREAM) && dat_end && !dat_err && (cnt_end == len);
   assign dup     = (state == DROP) && dat_end && !dat_err;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (hdr_v && seg_len != 16'd0) begin
               if (seg_seq == rcv_nxt && {16'd0, seg_len} <= free)
                  state_nx = STREAM;
               else
                  state_nx = DROP;
            end
         end
         STREAM, DROP: begin
            if (dat_end)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (init)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcv_nxt <= '0;
         ram_a   <= '0;
         ram_d   <= '0;
         ram_w   <= 1'b0;
         win     <= '0;
         ack     <= 1'b0;
         ooo     <= 1'b0;
         len     <= '0;
         cnt     <= '0;
         ptr     <= '0;
      end else begin
         win   <= win_nx;
         ram_w <= 1'b0;
         ack   <= 1'b0;
         ooo   <= 1'b0;
         if (init) begin
            rcv_nxt <= isn;
            cnt     <= '0;
         end else begin
            if (state == IDLE && hdr_v) begin
               len <= seg_len;
               cnt <= '0;
               if (state_nx == STREAM) begin
                  ptr   <= seg_seq[D-1:0];
                  ram_a <= seg_seq[D-1:0];
               end
            end
            // Address is the pre-increment pointer so it lines up with ram_w
            if (take) begin
               ram_w <= 1'b1;
               ram_d <= dat;
               ram_a <= ptr;
               ptr   <= ptr + {{(D-1){1'b0}}, 1'b1};
               cnt   <= cnt + 16'd1;
            end
            if (commit) begin
               rcv_nxt <= rcv_nxt + {16'd0, len};
               ack     <= 1'b1;
            end
            if (dup) begin
               ack <= 1'b1;
               ooo <= 1'b1;
            end
         end
      end
   end

endmodule
